// File: rtl/pkt_buf_pkg.sv
// Shared constants for the packet-buffer word reader: default address width,
// FSM state encodings and byte-lane keep masks.
package pkt_buf_pkg;

    localparam int ADDR_W_DEF = 11;

    localparam logic [2:0] WORD_BYTES = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] KEEP_NONE = 4'b0000;
    localparam logic [3:0] KEEP_1    = 4'b1000;
    localparam logic [3:0] KEEP_2    = 4'b1100;
    localparam logic [3:0] KEEP_3    = 4'b1110;
    localparam logic [3:0] KEEP_FULL = 4'b1111;

    // Keep mask is MSB-contiguous because byte 0 of a word lands in bits 31:24.
    function automatic logic [3:0] keep_for_count(input logic [2:0] n);
        logic [3:0] k;
        case (n)
            3'd0:    k = KEEP_NONE;
            3'd1:    k = KEEP_1;
            3'd2:    k = KEEP_2;
            3'd3:    k = KEEP_3;
            default: k = KEEP_FULL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/pkt_buf_word_reader_if.sv
// Bus bundle for the word reader: byte-wide packet-buffer read port plus the
// 32-bit output word stream with valid/ready handshake.
interface pkt_buf_word_reader_if import pkt_buf_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [7:0]        buf_rd_data;

    logic [31:0]       m_data;
    logic [3:0]        m_keep;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        output buf_rd_en,
        output buf_rd_addr,
        input  buf_rd_data,
        output m_data,
        output m_keep,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  buf_rd_en,
        input  buf_rd_addr,
        output buf_rd_data,
        input  m_data,
        input  m_keep,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/byte_to_word_packer.sv
// Accumulates bytes into a big-endian 32-bit word and exposes the word/keep
// value that results from shifting in the byte currently presented.
module byte_to_word_packer import pkt_buf_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_nxt,
    output logic [3:0]  o_keep_nxt
);

    logic [31:0] r_word;
    logic [2:0]  r_cnt;
    logic [31:0] w_word_nxt;

    always_comb begin
        w_word_nxt = r_word;
        case (r_cnt)
            3'd0:    w_word_nxt[31:24] = i_byte;
            3'd1:    w_word_nxt[23:16] = i_byte;
            3'd2:    w_word_nxt[15:8]  = i_byte;
            3'd3:    w_word_nxt[7:0]   = i_byte;
            default: w_word_nxt        = r_word;
        endcase
    end

    assign o_word_nxt = w_word_nxt;
    assign o_keep_nxt = keep_for_count(r_cnt + 3'd1);

    // Clear wins over shift: the completing byte is consumed via o_word_nxt.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift && (r_cnt < WORD_BYTES)) begin
            r_word <= w_word_nxt;
            r_cnt  <= r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/pkt_buf_word_reader.sv
// Reads a packet byte-by-byte from a packet buffer with one-cycle read latency
// and emits it as big-endian 32-bit words over a valid/ready stream.
module pkt_buf_word_reader import pkt_buf_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     byte_len,
    output logic                  busy,
    output logic                  done,
    pkt_buf_word_reader_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic              r_rd_pend;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_left;
    logic [2:0]        r_word_req;
    logic [31:0]       r_m_data;
    logic [3:0]        r_m_keep;
    logic              r_m_valid;
    logic              r_m_last;

    logic              w_word_done;
    logic              w_issue;
    logic [31:0]       w_word_nxt;
    logic [3:0]        w_keep_nxt;

    // Reads are back-to-back, so the last requested byte is arriving exactly
    // when data is pending and no newer read is outstanding.
    assign w_word_done = (r_state == ST_FETCH) && r_rd_pend && !r_rd_en;
    assign w_issue     = (r_word_req < WORD_BYTES) && (r_left != '0);

    byte_to_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_word_done),
        .i_shift    (r_rd_pend),
        .i_byte     (bus.buf_rd_data),
        .o_word_nxt (w_word_nxt),
        .o_keep_nxt (w_keep_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_addr  <= '0;
            r_left     <= '0;
            r_word_req <= '0;
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_rd_pend <= r_rd_en;
            case (r_state)
                ST_IDLE: begin
                    r_rd_en <= 1'b0;
                    if (start) begin
                        if (byte_len != '0) begin
                            r_state    <= ST_FETCH;
                            r_busy     <= 1'b1;
                            r_rd_en    <= 1'b1;
                            r_rd_addr  <= start_addr;
                            r_left     <= byte_len - ADDR_ONE;
                            r_word_req <= 3'd1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        r_rd_en    <= 1'b1;
                        r_rd_addr  <= r_rd_addr + ADDR_ONE;
                        r_left     <= r_left - ADDR_ONE;
                        r_word_req <= r_word_req + 3'd1;
                    end else begin
                        r_rd_en <= 1'b0;
                    end
                    if (w_word_done) begin
                        r_state   <= ST_SEND;
                        r_m_valid <= 1'b1;
                        r_m_data  <= w_word_nxt;
                        r_m_keep  <= w_keep_nxt;
                        r_m_last  <= (r_left == '0);
                    end
                end
                ST_SEND: begin
                    r_rd_en <= 1'b0;
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_data  <= '0;
                        r_m_keep  <= '0;
                        r_m_last  <= 1'b0;
                        if (r_m_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_rd_en    <= 1'b1;
                            r_rd_addr  <= r_rd_addr + ADDR_ONE;
                            r_left     <= r_left - ADDR_ONE;
                            r_word_req <= 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_rd_en <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign bus.buf_rd_en   = r_rd_en;
    assign bus.buf_rd_addr = r_rd_addr;
    assign bus.m_data      = r_m_data;
    assign bus.m_keep      = r_m_keep;
    assign bus.m_valid     = r_m_valid;
    assign bus.m_last      = r_m_last;

endmodule

// File: tb/tb_pkt_buf_word_reader.sv
// Directed bench for pkt_buf_word_reader with a one-cycle-latency buffer model.
module tb_pkt_buf_word_reader;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] byte_len;
    logic          busy;
    logic          done;

    pkt_buf_word_reader_if #(.ADDR_W(AW)) bus ();

    pkt_buf_word_reader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .byte_len   (byte_len),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]    mem [0:2047];
    logic [AW-1:0] rd_q [$];
    int            rd_cnt   = 0;
    int            word_cnt = 0;
    int            n_vec    = 0;
    int            n_err    = 0;

    always @(posedge clk) begin
        if (bus.buf_rd_en === 1'b1) begin
            bus.buf_rd_data <= mem[bus.buf_rd_addr];
            rd_q.push_back(bus.buf_rd_addr);
            rd_cnt++;
        end
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) word_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_pkt(input logic [AW-1:0] a, input logic [AW-1:0] l);
        start      = 1'b1;
        start_addr = a;
        byte_len   = l;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.m_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;
    int rd0;
    int wd0;
    int unstable;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[11'h010] = 8'hEF; mem[11'h011] = 8'h01; mem[11'h012] = 8'h02; mem[11'h013] = 8'h03;
        mem[11'h100] = 8'hAA; mem[11'h101] = 8'hBB; mem[11'h102] = 8'hCC;
        mem[11'h103] = 8'hDD; mem[11'h104] = 8'hEE; mem[11'h105] = 8'hFF;
        mem[11'h7FE] = 8'h11; mem[11'h7FF] = 8'h22; mem[11'h000] = 8'h33; mem[11'h001] = 8'h44;
        mem[11'h200] = 8'h5A; mem[11'h201] = 8'hA5; mem[11'h202] = 8'hC3; mem[11'h203] = 8'h3C;
        for (int i = 0; i < 8; i++) mem[11'h400 + i] = 8'(i + 1);

        bus.buf_rd_data = 8'h00;
        bus.m_ready     = 1'b1;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        byte_len   = '0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(bus.buf_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(bus.buf_rd_addr), 32'd0);
        chk("rst_m_data", bus.m_data, 32'd0);
        chk("rst_m_keep", 32'(bus.m_keep), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_last", 32'(bus.m_last), 32'd0);

        // Single full word, latency check
        rd_q.delete();
        start_pkt(11'h010, 11'd4);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_valid(n);
        chk("t1_latency", 32'(n), 32'd5);
        chk("t1_data", bus.m_data, 32'hEF010203);
        chk("t1_keep", 32'(bus.m_keep), 32'hF);
        chk("t1_last", 32'(bus.m_last), 32'd1);
        chk("t1_nreads", 32'(rd_q.size()), 32'd4);
        chk("t1_rd3", 32'(rd_q[3]), 32'h013);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_drop", 32'(busy), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Two words, partial final
        rd_q.delete();
        start_pkt(11'h100, 11'd6);
        wait_valid(n);
        chk("t2_w0_data", bus.m_data, 32'hAABBCCDD);
        chk("t2_w0_keep", 32'(bus.m_keep), 32'hF);
        chk("t2_w0_last", 32'(bus.m_last), 32'd0);
        tick();
        wait_valid(n);
        chk("t2_w1_data", bus.m_data, 32'hEEFF0000);
        chk("t2_w1_keep", 32'(bus.m_keep), 32'hC);
        chk("t2_w1_last", 32'(bus.m_last), 32'd1);
        tick();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_nreads", 32'(rd_q.size()), 32'd6);
        tick();

        // Address wrap
        rd_q.delete();
        start_pkt(11'h7FE, 11'd4);
        wait_valid(n);
        chk("t3_data", bus.m_data, 32'h11223344);
        chk("t3_nreads", 32'(rd_q.size()), 32'd4);
        chk("t3_rd0", 32'(rd_q[0]), 32'h7FE);
        chk("t3_rd1", 32'(rd_q[1]), 32'h7FF);
        chk("t3_rd2", 32'(rd_q[2]), 32'h000);
        chk("t3_rd3", 32'(rd_q[3]), 32'h001);
        tick();
        tick();

        // Backpressure plus start while busy
        bus.m_ready = 1'b0;
        start_pkt(11'h200, 11'd4);
        wait_valid(n);
        rd0 = rd_cnt;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                start      = 1'b1;
                start_addr = 11'h010;
                byte_len   = 11'd8;
            end
            tick();
            start = 1'b0;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h5AA5C33C || bus.m_keep !== 4'hF
                || bus.m_last !== 1'b1) unstable++;
        end
        chk("t4_stable", 32'(unstable), 32'd0);
        chk("t4_no_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        bus.m_ready = 1'b1;
        tick();
        chk("t4_done", 32'(done), 32'd1);
        tick();
        tick();
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_no_extra_reads", 32'(rd_cnt - rd0), 32'd0);

        // Zero-length packet, start during DONE ignored
        rd0 = rd_cnt;
        wd0 = word_cnt;
        start_pkt(11'h300, 11'd0);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        start      = 1'b1;
        start_addr = 11'h010;
        byte_len   = 11'd4;
        tick();
        start = 1'b0;
        chk("t5_done_pulse", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("t5_no_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("t5_no_words", 32'(word_cnt - wd0), 32'd0);
        chk("t5_no_valid", 32'(bus.m_valid), 32'd0);

        // Reset during second fetch; reset dominates start
        start_pkt(11'h400, 11'd8);
        wait_valid(n);
        chk("t6_w0_data", bus.m_data, 32'h01020304);
        tick();
        tick();
        reset      = 1'b1;
        start      = 1'b1;
        start_addr = 11'h010;
        byte_len   = 11'd4;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_rd_en", 32'(bus.buf_rd_en), 32'd0);
        chk("t6_rd_addr", 32'(bus.buf_rd_addr), 32'd0);
        chk("t6_outs", {bus.m_data[27:0], bus.m_keep}, 32'd0);
        chk("t6_data_hi", 32'(bus.m_data[31:28]), 32'd0);
        chk("t6_valid_last", {30'd0, bus.m_valid, bus.m_last}, 32'd0);
        rd0 = rd_cnt;
        wd0 = word_cnt;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_no_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("t6_no_words", 32'(word_cnt - wd0), 32'd0);
        start_pkt(11'h010, 11'd4);
        wait_valid(n);
        chk("t6_restart_data", bus.m_data, 32'hEF010203);
        tick();
        chk("t6_restart_done", 32'(done), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_buf_word_reader.md
PKT_BUF_WORD_READER -- requirements
Module: pkt_buf_word_reader

Interface
REQ-001 Parameter ADDR_W, default 11, packet-buffer byte-address width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to read one packet; sampled only in IDLE.
REQ-005 start_addr  in  ADDR_W  byte address of first packet byte.
REQ-006 byte_len  in  ADDR_W  packet length in bytes, 0..2^ADDR_W-1.
REQ-007 busy  out  1  high from start acceptance until done.
REQ-008 done  out  1  one-cycle pulse at end of packet.
REQ-009 buf_rd_en  out  1  packet-buffer read strobe.
REQ-010 buf_rd_addr  out  ADDR_W  packet-buffer byte address.
REQ-011 buf_rd_data  in  8  read data, valid exactly one cycle after buf_rd_en.
REQ-012 m_data  out  32  packed output word.
REQ-013 m_keep  out  4  byte-valid mask; keep[3] = bits 31:24.
REQ-014 m_valid  out  1  output word valid.
REQ-015 m_last  out  1  final word of packet.
REQ-016 m_ready  in  1  downstream accepts word when m_valid & m_ready.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, SEND, DONE.
REQ-018 IDLE: start=1 with byte_len!=0 latches start_addr/byte_len, goes to FETCH, sets busy.
REQ-019 IDLE: start=1 with byte_len=0 goes to DONE with no reads and no words.
REQ-020 FETCH: one read per cycle at consecutive addresses until word full (4 bytes) or packet exhausted, then SEND after last requested byte returns.
REQ-021 Address increment SHALL wrap modulo 2^ADDR_W (e.g. 0x7FF -> 0x000).
REQ-022 Packing big-endian: word byte i (i=0..3, packet order) at m_data[31-8i -: 8]; unfilled lanes 0x00, keep bit 0.
REQ-023 Full word: keep=4'b1111; partial final word: keep MSB-contiguous (1->1000, 2->1100, 3->1110).
REQ-024 m_valid SHALL rise 5 clock edges after the edge that samples start (full first word).
REQ-025 SEND: m_valid held high, m_data/m_keep/m_last stable until m_ready; m_valid never depends combinationally on m_ready.
REQ-026 SEND handshake: non-final word -> FETCH next cycle; final word -> DONE; no reads issued in SEND.
REQ-027 m_last SHALL be high only with the final word of the packet.
REQ-028 DONE: done=1 for exactly one cycle, busy drops, return to IDLE; start in DONE ignored.
REQ-029 start while busy SHALL be ignored without altering the transfer.
REQ-030 buf_rd_en low in IDLE, SEND, DONE; buf_rd_addr value irrelevant when buf_rd_en=0.

Reset
REQ-031 reset SHALL force IDLE and zero busy, done, buf_rd_en, buf_rd_addr, m_data, m_keep, m_valid, m_last.
REQ-032 reset mid-transfer SHALL abandon the partial word; no further reads or words until next start.
REQ-033 reset dominates start in the same cycle.

Structure
REQ-034 Package pkt_buf_pkg SHALL hold ADDR_W default, FSM state encodings, byte-lane keep constants.
REQ-035 Sub-module byte_to_word_packer (byte shift-in, lane count, keep generation) SHALL be instantiated once.

Verification
REQ-036 start_addr=0x010, len=4, bytes EF,01,02,03, m_ready=1 -> one word 0xEF010203, keep 1111, last=1, m_valid 5 edges after start, done pulse after handshake.
REQ-037 len=6, bytes AA..FF -> 0xAABBCCDD keep 1111 last 0, then 0xEEFF0000 keep 1100 last 1.
REQ-038 start_addr=0x7FE, len=4 -> reads 7FE,7FF,000,001 in order, one word.
REQ-039 len=4, m_ready low 10 cycles -> m_valid/m_data stable, no buf_rd_en, accept on m_ready.
REQ-040 len=0 -> no buf_rd_en, no m_valid, done pulse; start during busy ignored.
REQ-041 reset asserted during second fetch of len=8 -> all outputs 0 next cycle, no words until new start.
